// File: rtl/delay_scheduler_if.sv
// Signal-side bundle of delay_scheduler: the monitored input plus delayed outputs and status.
interface delay_scheduler_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned PW = $clog2(DEPTH + 1);

    logic          a;
    logic          out_inertial;
    logic          out_transport;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    // master drives the monitored signal; slave is the scheduler
    modport master (
        output a,
        input  out_inertial, out_transport, busy, pending, overflow
    );

    modport slave (
        input  a,
        output out_inertial, out_transport, busy, pending, overflow
    );
endinterface

// File: rtl/delay_scheduler.sv
// Clocked replacement for behavioural # delays: an inertial channel (single pending update,
// value sampled at expiry) and a transport channel (every edge queued and replayed in order).
module delay_scheduler #(
    parameter int unsigned DELAY = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = $clog2(DELAY + 1) + 1
) (
    input logic              clock,
    input logic              reset_n,
    delay_scheduler_if.slave bus
);
    localparam int unsigned CW = $clog2(DELAY + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [TW-1:0] due;
        logic          val;
    } event_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] now_q;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW-1:0] count_q, count_d;
    logic          a_q;
    logic          inert_q, inert_d;
    logic          trans_q, trans_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          edge_c, push_c, pop_c;
    event_t        head_c;
    event_t        mem [DEPTH];

    assign edge_c = (bus.a != a_q);

    // next-state for inertial FSM and transport FIFO bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inert_d = inert_q;
        trans_d = trans_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        head_c  = mem[rd_q];
        pop_c   = 1'b0;
        push_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (edge_c) begin
                    cnt_d   = CW'(DELAY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // edges while waiting are ignored; the output takes the value present at expiry
                if (cnt_q == CW'(1)) begin
                    inert_d = ~bus.a;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // only the head is compared: entries are pushed in due order
        pop_c  = (count_q != '0) && (head_c.due == now_q);
        push_c = edge_c && ((count_q != PW'(DEPTH)) || pop_c);

        if (pop_c) begin
            trans_d = head_c.val;
            rd_d    = rd_q + AW'(1);
        end
        if (push_c) begin
            wr_d = wr_q + AW'(1);
        end
        if (edge_c && !push_c) begin
            ovf_d = 1'b1;
        end
        count_d = count_q + PW'(push_c) - PW'(pop_c);
        busy_d  = (state_d == S_WAIT) || (count_d != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            now_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            a_q     <= 1'b0;
            inert_q <= 1'b1;
            trans_q <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            now_q   <= now_q + TW'(1);
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            a_q     <= bus.a;
            inert_q <= inert_d;
            trans_q <= trans_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    // payload storage needs no reset: occupancy gates every read
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_q] <= '{due: now_q + TW'(DELAY), val: ~bus.a};
        end
    end

    assign bus.out_inertial  = inert_q;
    assign bus.out_transport = trans_q;
    assign bus.busy          = busy_q;
    assign bus.pending       = count_q;
    assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_delay_scheduler.sv
// Directed + randomized bench for delay_scheduler against an absolute-time event-list model.
module tb_delay_scheduler;
    localparam int unsigned DELAY = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = $clog2(DELAY + 1) + 1;

    logic clock = 1'b0;
    logic reset_n;

    delay_scheduler_if #(.DEPTH(DEPTH)) bus ();

    delay_scheduler #(.DELAY(DELAY), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // reference model: absolute cycle numbers, no wrap, plain queue of scheduled events
    typedef struct {
        int unsigned due;
        logic        val;
    } ev_t;

    ev_t         q[$];
    int unsigned cyc;
    int unsigned expiry;
    bit          in_wait;
    logic        a_prev;
    logic        e_inert, e_trans, e_ovf;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cyc     = 0;
        expiry  = 0;
        in_wait = 1'b0;
        a_prev  = 1'b0;
        e_inert = 1'b1;
        e_trans = 1'b1;
        e_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic an);
        bit ev;
        cyc++;
        ev = (an != a_prev);
        if (in_wait && cyc == expiry) begin
            e_inert = ~an;
            in_wait = 1'b0;
        end else if (!in_wait && ev) begin
            in_wait = 1'b1;
            expiry  = cyc + DELAY;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e_trans = q[0].val;
            void'(q.pop_front());
        end
        if (ev) begin
            if (q.size() < DEPTH) q.push_back('{due: cyc + DELAY, val: ~an});
            else e_ovf = 1'b1;
        end
        a_prev = an;
    endtask

    task automatic check_all();
        check("inertial",  8'(bus.out_inertial),  8'(e_inert));
        check("transport", 8'(bus.out_transport), 8'(e_trans));
        check("busy",      8'(bus.busy),          8'(in_wait || q.size() != 0));
        check("pending",   8'(bus.pending),       8'(q.size()));
        check("overflow",  8'(bus.overflow),      8'(e_ovf));
    endtask

    // drive a, take one rising edge, sample 1 time unit later
    task automatic tick(input logic v);
        bus.a = v;
        @(posedge clock);
        model_step(v);
        #1;
        check_all();
    endtask

    task automatic hard_reset();
        bus.a = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #3 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.a   = 1'b0;
        model_reset();
        #12;
        check("rst_inertial",  8'(bus.out_inertial),  8'd1);
        check("rst_transport", 8'(bus.out_transport), 8'd1);
        check("rst_busy",      8'(bus.busy),          8'd0);
        check("rst_pending",   8'(bus.pending),       8'd0);
        check("rst_overflow",  8'(bus.overflow),      8'd0);
        reset_n = 1'b1;

        // single step: both outputs fall exactly DELAY edges later
        repeat (4) tick(1'b0);
        tick(1'b1);
        check("step_pending_1", 8'(bus.pending), 8'd1);
        for (int i = 1; i < int'(DELAY); i++) begin
            tick(1'b1);
            check("step_busy", 8'(bus.busy), 8'd1);
            check("step_hold", 8'(bus.out_transport), 8'd1);
        end
        tick(1'b1);
        check("step_inertial",  8'(bus.out_inertial),  8'd0);
        check("step_transport", 8'(bus.out_transport), 8'd0);
        check("step_idle",      8'(bus.busy),          8'd0);
        repeat (3) tick(1'b1);

        // glitch shorter than DELAY
        hard_reset();
        repeat (2) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        for (int i = 3; i <= 9; i++) begin
            tick(1'b0);
            if (i == 5) begin
                check("glitch_inertial",  8'(bus.out_inertial),  8'd1);
                check("glitch_trans_low", 8'(bus.out_transport), 8'd0);
            end
            if (i == 7) check("glitch_trans_high", 8'(bus.out_transport), 8'd1);
        end

        // overflow: fifth back-to-back edge is dropped, flag is sticky
        hard_reset();
        repeat (2) tick(1'b0);
        for (int i = 0; i < 5; i++) tick(i[0] ? 1'b0 : 1'b1);
        check("ovf_set",     8'(bus.overflow), 8'd1);
        check("ovf_pending", 8'(bus.pending),  8'(DEPTH));
        repeat (8) tick(1'b1);
        check("ovf_sticky", 8'(bus.overflow), 8'd1);

        // push and pop together while full
        hard_reset();
        repeat (2) tick(1'b0);
        for (int i = 0; i < 4; i++) tick(i[0] ? 1'b0 : 1'b1);
        tick(1'b0);
        tick(1'b1);
        check("full_pending",  8'(bus.pending),  8'(DEPTH));
        check("full_no_ovf",   8'(bus.overflow), 8'd0);
        repeat (8) tick(1'b1);

        // timestamp wrap: toggle every 7 cycles across several wraps of now
        for (int i = 0; i < 3 * (1 << TW) + 14; i++) begin
            tick((i % 7 == 0) ? ~bus.a : bus.a);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) == 0) ? ~bus.a : bus.a);
        end

        // asynchronous reset in the middle of activity
        hard_reset();
        repeat (2) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_inertial",  8'(bus.out_inertial),  8'd1);
        check("mid_rst_transport", 8'(bus.out_transport), 8'd1);
        check("mid_rst_busy",      8'(bus.busy),          8'd0);
        check("mid_rst_pending",   8'(bus.pending),       8'd0);
        model_reset();
        a_prev = 1'b0;
        #2 reset_n = 1'b1;
        bus.a = 1'b0;
        repeat (10) tick(1'b0);
        check("mid_rst_quiet", 8'(bus.out_transport), 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
